// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the five-stage core: load-use stalls,
// EX-resolved redirects, data-RAM wait freeze with timeout, and perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_write_reg_enable,
  input  logic [2:0]       ex_load_ram_flag,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_pause,
  output logic             if_id_pause,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic lu_match;
  logic mem_stall;
  logic decode_en;
  logic take_branch;
  logic load_use;

  assign lu_match = (ex_load_ram_flag != 3'd0) && ex_write_reg_enable &&
                    (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  // Decode runs in RUN and in the MEM_WAIT cycle where the RAM finally answers.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      ST_RUN:      mem_stall = mem_req & ~mem_ready;
      ST_MEM_WAIT: mem_stall = ~mem_ready;
      default:     mem_stall = 1'b1;
    endcase
    decode_en   = (state != ST_ERR) & ~mem_stall;
    take_branch = decode_en & ex_branch_taken;
    // Branch wins over load-use: the ID instruction is on the wrong path.
    load_use    = decode_en & ~ex_branch_taken & lu_match;
  end

  assign pc_pause       = rst & (mem_stall | load_use);
  assign if_id_pause    = rst & (mem_stall | load_use);
  assign if_id_flush    = rst & take_branch;
  assign id_ex_hold     = rst & mem_stall;
  assign id_ex_flush    = rst & (take_branch | load_use);
  assign ex_mem_hold    = rst & mem_stall;
  assign mem_wb_flush   = rst & mem_stall;
  assign redirect_valid = rst & take_branch;
  assign redirect_pc    = (rst & take_branch) ? ex_branch_target : 32'd0;
  assign dbg_state      = state;

  // The RUN cycle that first sees the stall is wait cycle 0, so MEM_WAIT starts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state           <= ST_ERR;
            mem_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        default: state <= ST_ERR;
      endcase

      if (pc_pause && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect_valid && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_uses_rs1, id_uses_rs2, ex_write_reg_enable;
  logic [2:0]    ex_load_ram_flag;
  logic          ex_branch_taken;
  logic [31:0]   ex_branch_target;
  logic          mem_req, mem_ready;
  logic          pc_pause, if_id_pause, if_id_flush, id_ex_hold, id_ex_flush;
  logic          ex_mem_hold, mem_wb_flush, redirect_valid, mem_timeout_err;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    dbg_state;

  int checks = 0;
  int fails  = 0;

  // model: stall run length, whether the previous cycle was a RAM stall, error flag
  bit m_err, m_wait;
  int m_len, m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_write_reg_enable(ex_write_reg_enable),
    .ex_load_ram_flag(ex_load_ram_flag), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
    .mem_wb_flush(mem_wb_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin : compare
    bit frz, redir, lu, match;
    if (!rst) begin
      m_err = 0; m_wait = 0; m_len = 0; m_stall = 0; m_flush = 0;
    end
    match = (ex_load_ram_flag != 0) && ex_write_reg_enable && (ex_rd_addr != 0) &&
            ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
             (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    if (!rst) begin
      frz = 0; redir = 0; lu = 0;
    end else begin
      frz   = m_err || (m_wait ? !mem_ready : (mem_req && !mem_ready));
      redir = !frz && ex_branch_taken;
      lu    = !frz && !ex_branch_taken && match;
    end
    check("m_pc_pause", pc_pause, frz || lu);
    check("m_if_id_pause", if_id_pause, frz || lu);
    check("m_if_id_flush", if_id_flush, redir);
    check("m_id_ex_hold", id_ex_hold, frz);
    check("m_id_ex_flush", id_ex_flush, redir || lu);
    check("m_ex_mem_hold", ex_mem_hold, frz);
    check("m_mem_wb_flush", mem_wb_flush, frz);
    check("m_redirect_valid", redirect_valid, redir);
    check("m_redirect_pc", redirect_pc, redir ? ex_branch_target : 32'd0);
    check("m_timeout_err", mem_timeout_err, m_err);
    check("m_stall_cnt", stall_cnt, m_stall);
    check("m_flush_cnt", flush_cnt, m_flush);
    check("m_state", dbg_state, m_err ? 2 : (m_wait ? 1 : 0));
    if (rst) begin
      if (frz && !m_err) begin
        m_len++;
        if (m_len >= TO) begin m_err = 1; m_wait = 0; end
        else m_wait = 1;
      end else if (!frz) begin
        m_len = 0; m_wait = 0;
      end
      if ((frz || lu) && m_stall < CMAX) m_stall++;
      if (redir && m_flush < CMAX) m_flush++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic set_idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd_addr = 0; ex_write_reg_enable = 0; ex_load_ram_flag = 0;
    ex_branch_taken = 0; ex_branch_target = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    rst = 0; set_idle(); cyc(); cyc(); rst = 1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_load_ram_flag = 3'd1; ex_write_reg_enable = 1; ex_rd_addr = rd;
    id_rs1_addr = rd; id_uses_rs1 = 1;
  endtask

  initial begin
    rst = 0; set_idle();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1; ex_branch_target = 32'hdead;
    at_neg();
    check("rst_pc_pause", pc_pause, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_state", dbg_state, 0);
    cyc();

    // load-use
    do_reset(); set_load_use(5'd5);
    at_neg();
    check("lu_pause", pc_pause, 1);
    check("lu_bubble", id_ex_flush, 1);
    check("lu_no_hold", id_ex_hold, 0);
    cyc(); set_idle();
    at_neg();
    check("lu_one_cycle", pc_pause, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    cyc(); set_load_use(5'd0);
    at_neg();
    check("lu_rd0_no_stall", pc_pause, 0);
    cyc(); set_idle();

    // branch
    do_reset(); ex_branch_taken = 1; ex_branch_target = 32'h100;
    at_neg();
    check("br_valid", redirect_valid, 1);
    check("br_pc", redirect_pc, 32'h100);
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    cyc(); ex_branch_taken = 0;
    at_neg();
    check("br_one_cycle", redirect_valid, 0);
    check("br_pc_zero", redirect_pc, 0);
    check("br_flush_cnt", flush_cnt, 1);
    cyc(); ex_branch_taken = 1; set_load_use(5'd7);
    at_neg();
    check("br_over_lu_pause", pc_pause, 0);
    check("br_over_lu_valid", redirect_valid, 1);
    cyc(); set_idle();

    // mem wait: three stall cycles then ready
    do_reset(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("mw_hold", id_ex_hold, 1);
      check("mw_wb_flush", mem_wb_flush, 1);
      cyc();
    end
    mem_ready = 1;
    at_neg();
    check("mw_release", pc_pause, 0);
    check("mw_state_wait", dbg_state, 1);
    cyc(); set_idle();
    at_neg();
    check("mw_stall_cnt", stall_cnt, 3);
    check("mw_state_run", dbg_state, 0);
    cyc();

    // branch held behind a two-cycle wait
    do_reset(); mem_req = 1; mem_ready = 0; ex_branch_taken = 1; ex_branch_target = 32'h2000;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check("bw_no_redirect", redirect_valid, 0);
      cyc();
    end
    mem_ready = 1;
    at_neg();
    check("bw_redirect", redirect_valid, 1);
    check("bw_pc", redirect_pc, 32'h2000);
    cyc(); set_idle();
    at_neg();
    check("bw_flush_cnt", flush_cnt, 1);
    check("bw_stall_cnt", stall_cnt, 2);
    cyc();

    // timeout, then asynchronous reset out of ERR
    do_reset(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      at_neg();
      check("to_early", mem_timeout_err, 0);
      cyc();
    end
    at_neg();
    check("to_err", mem_timeout_err, 1);
    check("to_state_err", dbg_state, 2);
    cyc(); mem_req = 0; mem_ready = 1;
    at_neg();
    check("to_freeze_pause", pc_pause, 1);
    check("to_freeze_hold", ex_mem_hold, 1);
    rst = 0; #1;
    check("to_rst_pause", pc_pause, 0);
    check("to_rst_wb", mem_wb_flush, 0);
    check("to_rst_err", mem_timeout_err, 0);
    check("to_rst_stall_cnt", stall_cnt, 0);
    check("to_rst_state", dbg_state, 0);
    cyc(); cyc(); rst = 1;

    // counter saturation
    do_reset(); mem_req = 1; mem_ready = 0;
    repeat (62) cyc();
    at_neg();
    check("sat_stall_62", stall_cnt, 62);
    cyc(); cyc(); cyc();
    at_neg();
    check("sat_stall_max", stall_cnt, 63);
    cyc();
    do_reset(); ex_branch_taken = 1;
    repeat (66) cyc();
    at_neg();
    check("sat_flush_max", flush_cnt, 63);
    cyc();

    // randomized traffic
    do_reset();
    repeat (3000) begin
      rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_rd_addr = 5'($urandom_range(0, 3));
      ex_write_reg_enable = 1'($urandom_range(0, 1));
      ex_load_ram_flag = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      ex_branch_target = $urandom;
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1; set_idle(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
